icache_ctrl_responder: RTL and testbench

- Cache-side end of the icache control-unit bus.
- Receives bypass, full-flush and selective-flush requests from the cluster icache control unit and sequences them into tag-array invalidations.
- Returns per-core and global bypass acknowledges, and flush acknowledges.
- When statistics are enabled, aggregates per-core hit and transaction pulses into the 32-bit counters read back by the control unit.

---
 rtl/icache_ctrl_responder.sv | 209 ++++++++++++++++++++
 tb/tb_icache_ctrl_responder.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl_responder.sv
// Purpose : cache-side end of the icache control bus; sequences full and selective flushes
//           into tag-array set invalidations, tracks bypass acks, aggregates hit/trans stats.
// Latency : bypass acks 1 cycle; selective flush ack 2 cycles after request; full flush NB_SETS+1.
// Backpr. : tag_inv_req_o/tag_inv_set_o hold stable until tag_inv_gnt_i; fetch_stall_o while invalidating.
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   bypass_req_i / bypass_ack_o        bypass request; per-core acks [NB_CORES-1:0], refill path [NB_CORES]
//   flush_req_i / flush_ack_o          full flush (level) / completion pulse for any flush
//   sel_flush_req_i/_addr_i/_ack_o     selective flush of the set holding a byte address
//   core_fetch_busy_i                  core has an outstanding fetch; its bypass ack must not move
//   hit_i, trans_i                     per-core statistic pulses
//   ctrl_clear_regs_i/_enable_regs_i   counter clear / enable
//   ctrl_hit_count_o/_trans_count_o    saturating 32-bit counters (zero when stats disabled)
//   tag_inv_req_o/_set_o/_gnt_i        tag-array invalidate handshake
//   fetch_stall_o                      cores must not start lookups
module icache_ctrl_responder #(
    parameter int unsigned NB_CORES     = 8,
    parameter int unsigned NB_SETS      = 128,
    parameter int unsigned SET_ID_WIDTH = $clog2(NB_SETS),
    parameter int unsigned OFFSET_WIDTH = 4,
    parameter bit          FEATURE_STAT = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    bypass_req_i,
    output logic [NB_CORES:0]       bypass_ack_o,
    input  logic                    flush_req_i,
    output logic                    flush_ack_o,
    input  logic                    sel_flush_req_i,
    input  logic [31:0]             sel_flush_addr_i,
    output logic                    sel_flush_ack_o,
    input  logic [NB_CORES-1:0]     core_fetch_busy_i,
    input  logic [NB_CORES-1:0]     hit_i,
    input  logic [NB_CORES-1:0]     trans_i,
    input  logic                    ctrl_clear_regs_i,
    input  logic                    ctrl_enable_regs_i,
    output logic [31:0]             ctrl_hit_count_o,
    output logic [31:0]             ctrl_trans_count_o,
    output logic                    tag_inv_req_o,
    output logic [SET_ID_WIDTH-1:0] tag_inv_set_o,
    input  logic                    tag_inv_gnt_i,
    output logic                    fetch_stall_o
);

    localparam int unsigned PW = $clog2(NB_CORES + 1);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH_WALK,
        SEL_INV,
        ACK,
        WAIT_LOW
    } state_e;

    state_e                  state_q, state_d;
    logic [SET_ID_WIDTH-1:0] set_cnt_q, set_cnt_d;
    logic [SET_ID_WIDTH-1:0] sel_set_q, sel_set_d;
    logic                    op_sel_q, op_sel_d;
    logic [NB_CORES:0]       bypass_ack_q;

    // Address bits outside the set index are irrelevant to invalidation.
    logic unused_addr;
    assign unused_addr = ^{sel_flush_addr_i[31:OFFSET_WIDTH+SET_ID_WIDTH],
                           sel_flush_addr_i[OFFSET_WIDTH-1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            set_cnt_q <= '0;
            sel_set_q <= '0;
            op_sel_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            set_cnt_q <= set_cnt_d;
            sel_set_q <= sel_set_d;
            op_sel_q  <= op_sel_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        set_cnt_d       = set_cnt_q;
        sel_set_d       = sel_set_q;
        op_sel_d        = op_sel_q;
        tag_inv_req_o   = 1'b0;
        tag_inv_set_o   = set_cnt_q;
        flush_ack_o     = 1'b0;
        sel_flush_ack_o = 1'b0;
        fetch_stall_o   = 1'b0;
        case (state_q)
            IDLE: begin
                // Full flush wins: it also covers whatever set the selective flush targets.
                if (flush_req_i) begin
                    set_cnt_d = '0;
                    op_sel_d  = 1'b0;
                    state_d   = FLUSH_WALK;
                end else if (sel_flush_req_i) begin
                    sel_set_d = sel_flush_addr_i[OFFSET_WIDTH +: SET_ID_WIDTH];
                    op_sel_d  = 1'b1;
                    state_d   = SEL_INV;
                end
            end
            FLUSH_WALK: begin
                tag_inv_req_o = 1'b1;
                fetch_stall_o = 1'b1;
                if (tag_inv_gnt_i) begin
                    // NB_SETS is a power of two, so the counter wraps to 0 on the last set.
                    set_cnt_d = set_cnt_q + {{(SET_ID_WIDTH-1){1'b0}}, 1'b1};
                    if (&set_cnt_q) begin
                        state_d = ACK;
                    end
                end
            end
            SEL_INV: begin
                tag_inv_req_o = 1'b1;
                tag_inv_set_o = sel_set_q;
                fetch_stall_o = 1'b1;
                if (tag_inv_gnt_i) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                flush_ack_o     = 1'b1;
                sel_flush_ack_o = op_sel_q;
                state_d         = WAIT_LOW;
            end
            WAIT_LOW: begin
                // Requests are levels: wait for both to drop so a held request is served once.
                if (!flush_req_i && !sel_flush_req_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A core's ack only moves while it has nothing in flight; the refill-path ack only
    // moves while no invalidation sequence is running.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bypass_ack_q <= '1;
        end else begin
            for (int i = 0; i < NB_CORES; i++) begin
                if (!core_fetch_busy_i[i]) begin
                    bypass_ack_q[i] <= bypass_req_i;
                end
            end
            if (state_q == IDLE) begin
                bypass_ack_q[NB_CORES] <= bypass_req_i;
            end
        end
    end

    assign bypass_ack_o = bypass_ack_q;

    function automatic logic [PW-1:0] popcnt(input logic [NB_CORES-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            c = c + {{(PW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [PW-1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {{(33-PW){1'b0}}, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    generate
        if (FEATURE_STAT) begin : g_stat
            logic [31:0] hit_cnt_q, hit_cnt_d;
            logic [31:0] trans_cnt_q, trans_cnt_d;

            always_comb begin
                hit_cnt_d   = hit_cnt_q;
                trans_cnt_d = trans_cnt_q;
                if (ctrl_clear_regs_i) begin
                    hit_cnt_d   = '0;
                    trans_cnt_d = '0;
                end else if (ctrl_enable_regs_i) begin
                    hit_cnt_d   = sat_add(hit_cnt_q, popcnt(hit_i));
                    trans_cnt_d = sat_add(trans_cnt_q, popcnt(trans_i));
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    hit_cnt_q   <= '0;
                    trans_cnt_q <= '0;
                end else begin
                    hit_cnt_q   <= hit_cnt_d;
                    trans_cnt_q <= trans_cnt_d;
                end
            end

            assign ctrl_hit_count_o   = hit_cnt_q;
            assign ctrl_trans_count_o = trans_cnt_q;
        end else begin : g_no_stat
            logic unused_stat;
            assign unused_stat        = ^{hit_i, trans_i, ctrl_clear_regs_i, ctrl_enable_regs_i};
            assign ctrl_hit_count_o   = '0;
            assign ctrl_trans_count_o = '0;
        end
    endgenerate

endmodule

// File: tb/tb_icache_ctrl_responder.sv
// Purpose : randomized and directed scoreboard bench for icache_ctrl_responder.
// Latency : expectations queued at stimulus time, popped when the DUT shows grants/acks.
// Backpr. : tag_inv_gnt_i driven randomly; held requests checked for stability.
module tb_icache_ctrl_responder;
    localparam int NB_CORES = 8;
    localparam int NB_SETS  = 128;
    localparam int SW       = 7;
    localparam int OW       = 4;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                bypass_req_i;
    logic [NB_CORES:0]   bypass_ack_o;
    logic                flush_req_i;
    logic                flush_ack_o;
    logic                sel_flush_req_i;
    logic [31:0]         sel_flush_addr_i;
    logic                sel_flush_ack_o;
    logic [NB_CORES-1:0] core_fetch_busy_i;
    logic [NB_CORES-1:0] hit_i;
    logic [NB_CORES-1:0] trans_i;
    logic                ctrl_clear_regs_i;
    logic                ctrl_enable_regs_i;
    logic [31:0]         ctrl_hit_count_o;
    logic [31:0]         ctrl_trans_count_o;
    logic                tag_inv_req_o;
    logic [SW-1:0]       tag_inv_set_o;
    logic                tag_inv_gnt_i;
    logic                fetch_stall_o;

    always #5 clk_i = ~clk_i;

    icache_ctrl_responder #(
        .NB_CORES(NB_CORES), .NB_SETS(NB_SETS), .SET_ID_WIDTH(SW),
        .OFFSET_WIDTH(OW), .FEATURE_STAT(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .bypass_req_i(bypass_req_i), .bypass_ack_o(bypass_ack_o),
        .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
        .sel_flush_req_i(sel_flush_req_i), .sel_flush_addr_i(sel_flush_addr_i),
        .sel_flush_ack_o(sel_flush_ack_o), .core_fetch_busy_i(core_fetch_busy_i),
        .hit_i(hit_i), .trans_i(trans_i),
        .ctrl_clear_regs_i(ctrl_clear_regs_i), .ctrl_enable_regs_i(ctrl_enable_regs_i),
        .ctrl_hit_count_o(ctrl_hit_count_o), .ctrl_trans_count_o(ctrl_trans_count_o),
        .tag_inv_req_o(tag_inv_req_o), .tag_inv_set_o(tag_inv_set_o),
        .tag_inv_gnt_i(tag_inv_gnt_i), .fetch_stall_o(fetch_stall_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard queues: expected invalidated sets in order, expected ack kinds (1 = selective).
    int inv_q[$];
    bit ack_q[$];

    // Reference model state.
    logic [NB_CORES-1:0] exp_byp;
    logic                exp_nb;
    bit                  nb_valid;
    longint              exp_hit, exp_trans;
    bit                  quiet   = 1'b1;   // no flush activity: refill-path ack follows bypass_req
    bit                  preload = 1'b0;   // hit counter being forced to a preset value
    int                  req_cycles, ungr_cycles;
    bit                  prev_pending;
    logic [SW-1:0]       prev_set;

    function automatic longint sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_byp   <= '1;
            exp_nb    <= 1'b1;
            nb_valid  <= 1'b1;
            exp_hit   <= 0;
            exp_trans <= 0;
        end else begin
            for (int i = 0; i < NB_CORES; i++) begin
                if (!core_fetch_busy_i[i]) exp_byp[i] <= bypass_req_i;
            end
            if (quiet) exp_nb <= bypass_req_i;
            nb_valid <= quiet;
            if (preload) begin
                exp_hit <= 64'hFFFF_FFFE;
            end else if (ctrl_clear_regs_i) begin
                exp_hit   <= 0;
                exp_trans <= 0;
            end else if (ctrl_enable_regs_i) begin
                exp_hit   <= sat32(exp_hit + longint'($countones(hit_i)));
                exp_trans <= sat32(exp_trans + longint'($countones(trans_i)));
            end
        end
    end

    // Monitor: samples on the falling edge.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("byp_core", bypass_ack_o[NB_CORES-1:0], exp_byp);
            if (nb_valid) check("byp_global", bypass_ack_o[NB_CORES], exp_nb);
            if (!preload) begin
                check("hit_count", ctrl_hit_count_o, exp_hit);
                check("trans_count", ctrl_trans_count_o, exp_trans);
            end
            check("stall_vs_req", fetch_stall_o, tag_inv_req_o);
            if (prev_pending) begin
                check("inv_hold_req", tag_inv_req_o, 1'b1);
                check("inv_hold_set", tag_inv_set_o, prev_set);
            end
            if (tag_inv_req_o) begin
                req_cycles++;
                if (!tag_inv_gnt_i) ungr_cycles++;
                if (inv_q.size() == 0) begin
                    check("inv_unexpected", tag_inv_req_o, 1'b0);
                end else if (tag_inv_gnt_i) begin
                    check("inv_set", tag_inv_set_o, inv_q.pop_front());
                end
            end
            prev_pending = tag_inv_req_o && !tag_inv_gnt_i;
            prev_set     = tag_inv_set_o;
            if (flush_ack_o) begin
                if (ack_q.size() == 0) check("ack_unexpected", flush_ack_o, 1'b0);
                else                   check("sel_ack", sel_flush_ack_o, ack_q.pop_front());
            end else begin
                check("sel_ack_alone", sel_flush_ack_o, 1'b0);
            end
        end else begin
            prev_pending = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Run until flush_ack_o is seen; returns the number of rising edges taken.
    task automatic wait_ack(input bit rand_gnt, input bit toggle_gnt, output int n);
        bit got;
        n   = 0;
        got = 1'b0;
        while (n < 2000 && !got) begin
            tick();
            n++;
            got = flush_ack_o;
            if (toggle_gnt)    tag_inv_gnt_i = ~tag_inv_gnt_i;
            else if (rand_gnt) tag_inv_gnt_i = ($urandom_range(0, 3) != 0);
            if (rand_gnt) begin
                bypass_req_i       = $urandom_range(0, 1);
                core_fetch_busy_i  = NB_CORES'($urandom);
                hit_i              = NB_CORES'($urandom);
                trans_i            = NB_CORES'($urandom);
                ctrl_enable_regs_i = $urandom_range(0, 1);
                ctrl_clear_regs_i  = ($urandom_range(0, 15) == 0);
            end
        end
        if (!got) check("ack_timeout", 1'b0, 1'b1);
    endtask

    task automatic push_full();
        for (int s = 0; s < NB_SETS; s++) inv_q.push_back(s);
        ack_q.push_back(1'b0);
    endtask

    initial begin
        int n;
        int op;
        logic [31:0] addr;

        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int op;
        logic [31:0] addr;

        bypass_req_i = 1'b1; flush_req_i = 1'b0; sel_flush_req_i = 1'b0;
        sel_flush_addr_i = '0; core_fetch_busy_i = '0; hit_i = '0; trans_i = '0;
        ctrl_clear_regs_i = 1'b0; ctrl_enable_regs_i = 1'b0; tag_inv_gnt_i = 1'b1;

        // Reset values
        rst_ni = 1'b0;
        repeat (3) tick();
        check("rst_bypass", bypass_ack_o, 9'h1FF);
        check("rst_flush_ack", flush_ack_o, 1'b0);
        check("rst_sel_ack", sel_flush_ack_o, 1'b0);
        check("rst_inv_req", tag_inv_req_o, 1'b0);
        check("rst_stall", fetch_stall_o, 1'b0);
        check("rst_hit", ctrl_hit_count_o, 32'd0);
        check("rst_trans", ctrl_trans_count_o, 32'd0);
        rst_ni = 1'b1;
        tick();

        // Bypass enable while core 3 is busy
        bypass_req_i = 1'b0;
        core_fetch_busy_i = 8'h08;
        tick();
        check("byp_busy3_held", bypass_ack_o, 9'h008);
        repeat (9) tick();
        check("byp_busy3_still", bypass_ack_o, 9'h008);
        core_fetch_busy_i = '0;
        tick();
        check("byp_busy3_clear", bypass_ack_o, 9'h000);

        // Full flush, gnt tied high: ack in cycle 129
        quiet = 1'b0;
        push_full();
        req_cycles = 0; ungr_cycles = 0;
        flush_req_i = 1'b1;
        n = 0;
        while (n < 400 && !flush_ack_o) begin
            tick();
            n++;
            if (n == 10) bypass_req_i = 1'b1;
            if (n == 20) check("byp_global_hold_walk", bypass_ack_o[NB_CORES], 1'b0);
        end
        check("full_ack_cycle", n, 129);
        check("full_req_cycles", req_cycles, 128);
        tick();
        flush_req_i = 1'b0;
        tick();
        tick();
        check("idle_by_131", bypass_ack_o[NB_CORES], 1'b1);
        check("full_queue_empty", inv_q.size(), 0);
        quiet = 1'b1;
        tick();

        // Full flush with gnt toggling 1-0-1
        quiet = 1'b0;
        push_full();
        req_cycles = 0; ungr_cycles = 0;
        flush_req_i = 1'b1;
        wait_ack(1'b0, 1'b1, n);
        check("toggle_req_cycles", req_cycles, 128 + ungr_cycles);
        tick();
        flush_req_i = 1'b0;
        tag_inv_gnt_i = 1'b1;
        repeat (2) tick();
        quiet = 1'b1;
        tick();

        // Selective flush of 32'h1C00_0A50, request held after ack
        quiet = 1'b0;
        inv_q.push_back(7'h25);
        ack_q.push_back(1'b1);
        sel_flush_addr_i = 32'h1C00_0A50;
        sel_flush_req_i = 1'b1;
        tick();
        check("sel_inv_set", tag_inv_set_o, 7'h25);
        check("sel_inv_req", tag_inv_req_o, 1'b1);
        tick();
        check("sel_flush_ack", flush_ack_o, 1'b1);
        check("sel_sel_ack", sel_flush_ack_o, 1'b1);
        repeat (5) tick();
        sel_flush_req_i = 1'b0;
        repeat (2) tick();
        quiet = 1'b1;
        tick();

        // Randomized flush traffic
        for (int k = 0; k < 8; k++) begin
            quiet = 1'b0;
            op   = $urandom_range(0, 2);
            addr = $urandom;
            sel_flush_addr_i = addr;
            if (op == 1) begin
                inv_q.push_back(int'((addr >> OW) % NB_SETS));
                ack_q.push_back(1'b1);
                sel_flush_req_i = 1'b1;
            end else begin
                push_full();
                flush_req_i = 1'b1;
                sel_flush_req_i = (op == 2);
            end
            wait_ack(1'b1, 1'b0, n);
            repeat ($urandom_range(1, 4)) tick();
            flush_req_i = 1'b0;
            sel_flush_req_i = 1'b0;
            repeat (2) tick();
            quiet = 1'b1;
            tick();
        end
        core_fetch_busy_i = '0; hit_i = '0; trans_i = '0;
        ctrl_enable_regs_i = 1'b0; ctrl_clear_regs_i = 1'b0; tag_inv_gnt_i = 1'b1;
        tick();

        // Counters: 3 cycles of all hits after clear
        ctrl_clear_regs_i = 1'b1;
        tick();
        ctrl_clear_regs_i = 1'b0;
        ctrl_enable_regs_i = 1'b1;
        hit_i = 8'hFF;
        repeat (3) tick();
        ctrl_enable_regs_i = 1'b0;
        hit_i = '0;
        tick();
        check("hit_24", ctrl_hit_count_o, 32'd24);

        // Saturation from a preset value
        force dut.g_stat.hit_cnt_q = 32'hFFFF_FFFE;
        preload = 1'b1;
        tick();
        release dut.g_stat.hit_cnt_q;
        preload = 1'b0;
        ctrl_enable_regs_i = 1'b1;
        hit_i = 8'hFF;
        repeat (2) tick();
        ctrl_enable_regs_i = 1'b0;
        hit_i = '0;
        tick();
        check("hit_saturate", ctrl_hit_count_o, 32'hFFFF_FFFF);

        // Clear wins over simultaneous increments
        ctrl_clear_regs_i = 1'b1;
        ctrl_enable_regs_i = 1'b1;
        hit_i = 8'h0F;
        tick();
        ctrl_clear_regs_i = 1'b0;
        ctrl_enable_regs_i = 1'b0;
        hit_i = '0;
        check("hit_clear", ctrl_hit_count_o, 32'd0);

        // Reset in the middle of a walk
        quiet = 1'b0;
        bypass_req_i = 1'b0;
        push_full();
        flush_req_i = 1'b1;
        repeat (40) tick();
        rst_ni = 1'b0;
        inv_q.delete();
        ack_q.delete();
        flush_req_i = 1'b0;
        #1;
        check("rst_mid_inv_req", tag_inv_req_o, 1'b0);
        check("rst_mid_ack", flush_ack_o, 1'b0);
        check("rst_mid_bypass", bypass_ack_o, 9'h1FF);
        tick();
        rst_ni = 1'b1;
        tick();
        inv_q.push_back(int'((32'h0000_0330 >> OW) % NB_SETS));
        ack_q.push_back(1'b1);
        sel_flush_addr_i = 32'h0000_0330;
        sel_flush_req_i = 1'b1;
        tick();
        check("post_rst_sel_set", tag_inv_set_o, 7'h33);
        tick();
        check("post_rst_ack", flush_ack_o, 1'b1);
        sel_flush_req_i = 1'b0;
        repeat (3) tick();
        check("final_inv_queue", inv_q.size(), 0);
        check("final_ack_queue", ack_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
